// File: rtl/fadd36_pkg.sv
// Shared constants and tag type for the two-port adder arbiter.
// Defaults here are the top-level parameter defaults.
package fadd36_pkg;

    localparam int W_DEF         = 36;
    localparam int LAT_DEF       = 3;
    localparam int RSP_DEPTH_DEF = 2;

    typedef logic port_t;

    typedef struct packed {
        logic  vld;
        port_t port;
    } tag_t;

endpackage

// File: rtl/fadd36_arb_if.sv
// Shared-adder bus: the arbiter issues operands, the adder returns results.
interface fadd36_arb_if #(
    parameter int W = 36
);
    logic         add_vld;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         res_vld;
    logic [W-1:0] res;

    modport master (
        output add_vld, op_a, op_b,
        input  res_vld, res
    );

    modport slave (
        input  add_vld, op_a, op_b,
        output res_vld, res
    );
endinterface

// File: rtl/fadd36_rsp_fifo.sv
// Per-port response FIFO; a push into a full FIFO is accepted only with a pop.
module fadd36_rsp_fifo #(
    parameter int W         = 36,
    parameter int RSP_DEPTH = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic         o_full,
    output logic         o_empty,
    output logic [W-1:0] o_head
);
    localparam int AW = $clog2(RSP_DEPTH);
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam logic [AW-1:0] LAST    = AW'(RSP_DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);

    logic [W-1:0]  mem_q [RSP_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign o_full  = (cnt_q == DEPTH_C);
    assign o_empty = (cnt_q == '0);
    assign o_head  = mem_q[rd_q];
    assign do_pop  = i_pop & ~o_empty;
    assign do_push = i_push & (~o_full | do_pop);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        if (do_push) wr_d = (wr_q == LAST) ? '0 : wr_q + 1'b1;
        if (do_pop)  rd_d = (rd_q == LAST) ? '0 : rd_q + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_q] <= i_data;
    end
endmodule

// File: rtl/fadd36_arb.sv
// Two-port round-robin front end for one shared fixed-latency adder,
// with credit-gated per-port response FIFOs.
module fadd36_arb
    import fadd36_pkg::*;
#(
    parameter int W         = W_DEF,
    parameter int LAT       = LAT_DEF,
    parameter int RSP_DEPTH = RSP_DEPTH_DEF
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic [1:0]     i_req_vld,
    output logic [1:0]     o_req_rdy,
    input  logic [2*W-1:0] i_req_op_a,
    input  logic [2*W-1:0] i_req_op_b,
    output logic           o_add_vld,
    output logic [W-1:0]   o_add_op_a,
    output logic [W-1:0]   o_add_op_b,
    input  logic           i_add_res_vld,
    input  logic [W-1:0]   i_add_res,
    output logic [1:0]     o_rsp_vld,
    output logic [2*W-1:0] o_rsp_data,
    input  logic [1:0]     i_rsp_rdy,
    output logic           o_err
);
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);

    logic [1:0]          elig, gnt, push, pop, drop, full, empty;
    logic                ptr_q, ptr_d;
    logic [1:0][CW-1:0]  cred_q, cred_d;
    tag_t                iss_q, iss_d;
    tag_t [LAT-1:0]      tag_q;
    tag_t                tag_out;
    logic [W-1:0]        op_a_q, op_b_q;
    logic                err_q, err_d;

    assign tag_out = tag_q[LAT-1];

    always_comb begin
        elig = '0;
        gnt  = '0;
        for (int p = 0; p < 2; p++)
            elig[p] = i_req_vld[p] & (cred_q[p] < DEPTH_C);
        if (elig[ptr_q])       gnt[ptr_q]  = 1'b1;
        else if (elig[~ptr_q]) gnt[~ptr_q] = 1'b1;
    end

    // Credit counts in-flight tags plus FIFO occupancy, so a push never overflows.
    always_comb begin
        push   = '0;
        drop   = '0;
        pop    = '0;
        cred_d = cred_q;
        for (int p = 0; p < 2; p++) begin
            push[p] = i_add_res_vld & tag_out.vld & (tag_out.port == port_t'(p));
            drop[p] = ~i_add_res_vld & tag_out.vld & (tag_out.port == port_t'(p));
            pop[p]  = ~empty[p] & i_rsp_rdy[p];
            cred_d[p] = cred_q[p] + CW'(gnt[p]) - CW'(pop[p]) - CW'(drop[p]);
        end
        iss_d = '{vld: |gnt, port: gnt[1]};
        ptr_d = (|gnt) ? ~gnt[1] : ptr_q;
        err_d = err_q | (i_add_res_vld ^ tag_out.vld) | (|(push & full & ~pop));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            iss_q  <= '0;
            tag_q  <= '0;
            cred_q <= '0;
            ptr_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            iss_q    <= iss_d;
            tag_q[0] <= iss_q;
            for (int k = 1; k < LAT; k++) tag_q[k] <= tag_q[k-1];
            cred_q <= cred_d;
            ptr_q  <= ptr_d;
            err_q  <= err_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (|gnt) begin
            op_a_q <= gnt[1] ? i_req_op_a[W +: W] : i_req_op_a[0 +: W];
            op_b_q <= gnt[1] ? i_req_op_b[W +: W] : i_req_op_b[0 +: W];
        end
    end

    assign o_req_rdy  = gnt & {2{i_rst_n}};
    assign o_add_vld  = iss_q.vld;
    assign o_add_op_a = op_a_q;
    assign o_add_op_b = op_b_q;
    assign o_rsp_vld  = ~empty;
    assign o_err      = err_q;

    for (genvar p = 0; p < 2; p++) begin : g_fifo
        fadd36_rsp_fifo #(
            .W         (W),
            .RSP_DEPTH (RSP_DEPTH)
        ) u_fifo (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_push  (push[p]),
            .i_data  (i_add_res),
            .i_pop   (pop[p]),
            .o_full  (full[p]),
            .o_empty (empty[p]),
            .o_head  (o_rsp_data[p*W +: W])
        );
    end
endmodule

// File: tb/tb_fadd36_arb.sv
// Bench for fadd36_arb: pipelined adder model plus per-port response scoreboard.
module tb_fadd36_arb;
    localparam int W   = 36;
    localparam int LAT = 3;
    localparam int D   = 2;
    // Operands are fixed point with 18 fractional bits, so 1.0 = 1 << 18.
    localparam logic [W-1:0] ONE   = W'(1) << 18;
    localparam logic [W-1:0] TWO   = W'(2) << 18;
    localparam logic [W-1:0] THREE = W'(3) << 18;
    localparam logic [W-1:0] FIVE  = W'(5) << 18;
    localparam logic [W-1:0] SIX   = W'(6) << 18;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [1:0]     req_vld = '0;
    logic [1:0]     req_rdy;
    logic [2*W-1:0] req_a = '0;
    logic [2*W-1:0] req_b = '0;
    logic [1:0]     rsp_vld;
    logic [2*W-1:0] rsp_data;
    logic [1:0]     rsp_rdy = 2'b11;
    logic           err;
    logic           spur = 1'b0;

    int vecs = 0;
    int errs = 0;
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];

    fadd36_arb_if #(.W(W)) bus ();

    fadd36_arb #(.W(W), .LAT(LAT), .RSP_DEPTH(D)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req_vld     (req_vld),
        .o_req_rdy     (req_rdy),
        .i_req_op_a    (req_a),
        .i_req_op_b    (req_b),
        .o_add_vld     (bus.add_vld),
        .o_add_op_a    (bus.op_a),
        .o_add_op_b    (bus.op_b),
        .i_add_res_vld (bus.res_vld),
        .i_add_res     (bus.res),
        .o_rsp_vld     (rsp_vld),
        .o_rsp_data    (rsp_data),
        .i_rsp_rdy     (rsp_rdy),
        .o_err         (err)
    );

    always #5 clk = ~clk;

    logic         pv [LAT];
    logic [W-1:0] pd [LAT];
    always @(posedge clk) begin
        pv[0] <= bus.add_vld;
        pd[0] <= bus.op_a + bus.op_b;
        for (int i = 1; i < LAT; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
        end
    end
    assign bus.res_vld = pv[LAT-1] | spur;
    assign bus.res     = pd[LAT-1];

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst_n) begin
            if (rsp_vld[0] && rsp_rdy[0]) begin
                vecs++;
                if (q0.size() == 0) begin
                    errs++;
                    $display("FAIL rsp0_unexpected got=%h exp=none", rsp_data[0 +: W]);
                end else begin
                    e = q0.pop_front();
                    if (rsp_data[0 +: W] !== e) begin
                        errs++;
                        $display("FAIL rsp0_data got=%h exp=%h", rsp_data[0 +: W], e);
                    end
                end
            end
            if (rsp_vld[1] && rsp_rdy[1]) begin
                vecs++;
                if (q1.size() == 0) begin
                    errs++;
                    $display("FAIL rsp1_unexpected got=%h exp=none", rsp_data[W +: W]);
                end else begin
                    e = q1.pop_front();
                    if (rsp_data[W +: W] !== e) begin
                        errs++;
                        $display("FAIL rsp1_data got=%h exp=%h", rsp_data[W +: W], e);
                    end
                end
            end
            if (req_vld[0] && req_rdy[0]) q0.push_back(req_a[0 +: W] + req_b[0 +: W]);
            if (req_vld[1] && req_rdy[1]) q1.push_back(req_a[W +: W] + req_b[W +: W]);
        end
    end

    task automatic apply_reset(input int n);
        rst_n   = 1'b0;
        req_vld = '0;
        spur    = 1'b0;
        q0.delete();
        q1.delete();
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rand_ops();
        req_a = {W'($urandom_range(0, 1 << 20)), W'($urandom_range(0, 1 << 20))};
        req_b = {W'($urandom_range(0, 1 << 20)), W'($urandom_range(0, 1 << 20))};
    endtask

    task automatic test_reset();
        req_vld = 2'b11;
        #1;
        vecs += 4;
        if (bus.add_vld !== 1'b0) begin errs++; $display("FAIL rst_add_vld got=%b exp=0", bus.add_vld); end
        if (rsp_vld !== 2'b00) begin errs++; $display("FAIL rst_rsp_vld got=%b exp=00", rsp_vld); end
        if (req_rdy !== 2'b00) begin errs++; $display("FAIL rst_req_rdy got=%b exp=00", req_rdy); end
        if (err !== 1'b0) begin errs++; $display("FAIL rst_err got=%b exp=0", err); end
        apply_reset(LAT + 2);
    endtask

    task automatic test_single();
        int t_add = -1;
        int t_rsp = -1;
        logic [W-1:0] ga = '0, gb = '0, gr = '0;
        @(posedge clk); #1;
        req_vld = 2'b01;
        req_a[0 +: W] = ONE;
        req_b[0 +: W] = TWO;
        @(negedge clk);
        vecs++;
        if (req_rdy !== 2'b01) begin errs++; $display("FAIL single_rdy got=%b exp=01", req_rdy); end
        @(posedge clk); #1;
        req_vld = '0;
        for (int c = 1; c <= LAT + 5; c++) begin
            @(negedge clk);
            if (bus.add_vld && t_add < 0) begin t_add = c; ga = bus.op_a; gb = bus.op_b; end
            if (rsp_vld[0] && t_rsp < 0) begin t_rsp = c; gr = rsp_data[0 +: W]; end
        end
        vecs += 5;
        if (t_add !== 1) begin errs++; $display("FAIL single_add_cycle got=%0d exp=1", t_add); end
        if (ga !== ONE || gb !== TWO) begin errs++; $display("FAIL single_add_ops got=%h,%h exp=%h,%h", ga, gb, ONE, TWO); end
        if (t_rsp !== LAT + 2) begin errs++; $display("FAIL single_rsp_cycle got=%0d exp=%0d", t_rsp, LAT + 2); end
        if (gr !== THREE) begin errs++; $display("FAIL single_rsp_data got=%h exp=%h", gr, THREE); end
        if (err !== 1'b0) begin errs++; $display("FAIL single_err got=%b exp=0", err); end
    endtask

    task automatic test_alternate();
        logic exp_port = 1'b0;
        int fires = 0;
        apply_reset(2);
        rsp_rdy = 2'b11;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            req_vld = 2'b11;
            rand_ops();
            @(negedge clk);
            if (req_rdy != 2'b00) begin
                vecs++;
                fires++;
                if (req_rdy !== (exp_port ? 2'b10 : 2'b01)) begin
                    errs++;
                    $display("FAIL alt_grant got=%b exp_port=%0d", req_rdy, exp_port);
                end
                exp_port = ~exp_port;
            end
        end
        @(posedge clk); #1;
        req_vld = '0;
        repeat (LAT + 6) @(negedge clk);
        vecs += 3;
        if (fires < 4) begin errs++; $display("FAIL alt_fires got=%0d exp>=4", fires); end
        if (err !== 1'b0) begin errs++; $display("FAIL alt_err got=%b exp=0", err); end
        if (q0.size() + q1.size() != 0) begin errs++; $display("FAIL alt_drain got=%0d exp=0", q0.size() + q1.size()); end
    endtask

    task automatic test_backpressure();
        int n0 = 0;
        int n1 = 0;
        apply_reset(2);
        rsp_rdy = 2'b01;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk); #1;
            req_vld = 2'b11;
            rand_ops();
            @(negedge clk);
            if (req_rdy[0]) n0++;
            if (req_rdy[1]) n1++;
        end
        vecs += 5;
        if (n1 !== D) begin errs++; $display("FAIL bp_port1_accepts got=%0d exp=%0d", n1, D); end
        if (n0 < 2 * D) begin errs++; $display("FAIL bp_port0_accepts got=%0d exp>=%0d", n0, 2 * D); end
        if (req_rdy[1] !== 1'b0) begin errs++; $display("FAIL bp_rdy1 got=%b exp=0", req_rdy[1]); end
        if (rsp_vld[1] !== 1'b1) begin errs++; $display("FAIL bp_rsp_vld1 got=%b exp=1", rsp_vld[1]); end
        if (err !== 1'b0) begin errs++; $display("FAIL bp_err got=%b exp=0", err); end
        @(posedge clk); #1;
        req_vld = '0;
        rsp_rdy = 2'b11;
        repeat (2 * LAT + 8) @(negedge clk);
        vecs++;
        if (q0.size() + q1.size() != 0) begin errs++; $display("FAIL bp_drain got=%0d exp=0", q0.size() + q1.size()); end
    endtask

    task automatic test_spurious();
        apply_reset(2);
        @(posedge clk); #1;
        spur = 1'b1;
        @(negedge clk);
        vecs++;
        if (err !== 1'b0) begin errs++; $display("FAIL spur_err_early got=%b exp=0", err); end
        @(posedge clk); #1;
        spur = 1'b0;
        @(negedge clk);
        vecs += 2;
        if (err !== 1'b1) begin errs++; $display("FAIL spur_err got=%b exp=1", err); end
        if (rsp_vld !== 2'b00) begin errs++; $display("FAIL spur_rsp_vld got=%b exp=00", rsp_vld); end
        repeat (5) @(negedge clk);
        vecs++;
        if (err !== 1'b1) begin errs++; $display("FAIL spur_err_hold got=%b exp=1", err); end
    endtask

    task automatic test_reset_mid();
        int t_rsp = -1;
        logic [W-1:0] gr = '0;
        apply_reset(2);
        rsp_rdy = 2'b11;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            req_vld = (c == 1) ? 2'b10 : 2'b01;
            rand_ops();
        end
        @(posedge clk); #1;
        req_vld = '0;
        #2;
        vecs++;
        if (bus.add_vld !== 1'b1) begin errs++; $display("FAIL mid_inflight got=%b exp=1", bus.add_vld); end
        rst_n = 1'b0;
        #1;
        vecs += 4;
        if (bus.add_vld !== 1'b0) begin errs++; $display("FAIL mid_add_vld got=%b exp=0", bus.add_vld); end
        if (rsp_vld !== 2'b00) begin errs++; $display("FAIL mid_rsp_vld got=%b exp=00", rsp_vld); end
        if (req_rdy !== 2'b00) begin errs++; $display("FAIL mid_req_rdy got=%b exp=00", req_rdy); end
        if (err !== 1'b0) begin errs++; $display("FAIL mid_err got=%b exp=0", err); end
        apply_reset(LAT + 3);
        @(posedge clk); #1;
        req_vld = 2'b10;
        req_a[W +: W] = FIVE;
        req_b[W +: W] = ONE;
        @(posedge clk); #1;
        req_vld = '0;
        for (int c = 1; c <= LAT + 5; c++) begin
            @(negedge clk);
            if (rsp_vld[1] && t_rsp < 0) begin t_rsp = c; gr = rsp_data[W +: W]; end
        end
        vecs += 3;
        if (t_rsp !== LAT + 2) begin errs++; $display("FAIL mid_rsp_cycle got=%0d exp=%0d", t_rsp, LAT + 2); end
        if (gr !== SIX) begin errs++; $display("FAIL mid_rsp_data got=%h exp=%h", gr, SIX); end
        if (err !== 1'b0) begin errs++; $display("FAIL mid_err_after got=%b exp=0", err); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_spurious();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
